// File: rtl/falafel_mux.sv
// Round-robin funnel from N_CLIENTS alloc/free request ports onto one downstream
// allocator, with one buffered request per client and one transaction in flight.

module falafel_mux_slot #(
    parameter int DATA_W = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_val_i,
    input  logic              is_alloc_i,
    input  logic [DATA_W-1:0] size_i,
    input  logic [DATA_W-1:0] addr_i,
    input  logic              clr_i,
    output logic              full_o,
    output logic              is_alloc_o,
    output logic [DATA_W-1:0] size_o,
    output logic [DATA_W-1:0] addr_o
);
    // Loading needs an empty slot and clearing needs a full one, so the two never collide.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_o     <= 1'b0;
            is_alloc_o <= 1'b0;
            size_o     <= '0;
            addr_o     <= '0;
        end else if (!full_o && req_val_i) begin
            full_o     <= 1'b1;
            is_alloc_o <= is_alloc_i;
            size_o     <= size_i;
            addr_o     <= addr_i;
        end else if (clr_i) begin
            full_o     <= 1'b0;
        end
    end
endmodule

module falafel_mux #(
    parameter int DATA_W    = 64,
    parameter int N_CLIENTS = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [N_CLIENTS-1:0]          cli_req_val_i,
    output logic [N_CLIENTS-1:0]          cli_req_rdy_o,
    input  logic [N_CLIENTS-1:0]          cli_is_alloc_i,
    input  logic [N_CLIENTS*DATA_W-1:0]   cli_size_i,
    input  logic [N_CLIENTS*DATA_W-1:0]   cli_addr_i,
    output logic [N_CLIENTS-1:0]          cli_rsp_val_o,
    input  logic [N_CLIENTS-1:0]          cli_rsp_rdy_i,
    output logic [DATA_W-1:0]             cli_rsp_addr_o,
    output logic                          cli_rsp_ok_o,
    output logic                          alloc_req_val_o,
    input  logic                          alloc_req_rdy_i,
    output logic                          alloc_is_alloc_o,
    output logic [DATA_W-1:0]             alloc_size_o,
    output logic [DATA_W-1:0]             alloc_addr_o,
    output logic [((N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1)-1:0] alloc_id_o,
    input  logic                          alloc_rsp_val_i,
    output logic                          alloc_rsp_rdy_o,
    input  logic [DATA_W-1:0]             alloc_rsp_addr_i,
    input  logic                          alloc_rsp_ok_i,
    output logic                          proto_err_o
);
    localparam int ID_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                           state;
    logic [ID_W-1:0]                  grant;
    logic [ID_W-1:0]                  rr_ptr;
    logic [N_CLIENTS-1:0]             slot_full;
    logic [N_CLIENTS-1:0]             slot_alloc;
    logic [N_CLIENTS-1:0][DATA_W-1:0] slot_size;
    logic [N_CLIENTS-1:0][DATA_W-1:0] slot_addr;
    logic [N_CLIENTS-1:0]             slot_clr;
    logic                             pick_found;
    logic [ID_W-1:0]                  pick_idx;
    logic [ID_W-1:0]                  next_rr;
    int                               idx;

    for (genvar i = 0; i < N_CLIENTS; i++) begin : g_slot
        falafel_mux_slot #(.DATA_W(DATA_W)) u_slot (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .req_val_i  (cli_req_val_i[i]),
            .is_alloc_i (cli_is_alloc_i[i]),
            .size_i     (cli_size_i[i*DATA_W +: DATA_W]),
            .addr_i     (cli_addr_i[i*DATA_W +: DATA_W]),
            .clr_i      (slot_clr[i]),
            .full_o     (slot_full[i]),
            .is_alloc_o (slot_alloc[i]),
            .size_o     (slot_size[i]),
            .addr_o     (slot_addr[i])
        );
    end

    assign cli_req_rdy_o = ~slot_full;

    // Scan from farthest to nearest offset so the slot closest to rr_ptr wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        for (int off = N_CLIENTS - 1; off >= 0; off--) begin
            idx = (int'(rr_ptr) + off) % N_CLIENTS;
            if (slot_full[idx]) begin
                pick_found = 1'b1;
                pick_idx   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        slot_clr = '0;
        if (state == RESP && cli_rsp_rdy_i[grant])
            slot_clr[grant] = 1'b1;
    end

    assign next_rr = (grant == ID_W'(N_CLIENTS - 1)) ? '0 : grant + ID_W'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state            <= IDLE;
            grant            <= '0;
            rr_ptr           <= '0;
            proto_err_o      <= 1'b0;
            alloc_req_val_o  <= 1'b0;
            alloc_is_alloc_o <= 1'b0;
            alloc_size_o     <= '0;
            alloc_addr_o     <= '0;
            alloc_id_o       <= '0;
            alloc_rsp_rdy_o  <= 1'b0;
            cli_rsp_val_o    <= '0;
            cli_rsp_addr_o   <= '0;
            cli_rsp_ok_o     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (pick_found) begin
                    grant            <= pick_idx;
                    alloc_req_val_o  <= 1'b1;
                    alloc_is_alloc_o <= slot_alloc[pick_idx];
                    alloc_size_o     <= slot_size[pick_idx];
                    alloc_addr_o     <= slot_addr[pick_idx];
                    alloc_id_o       <= pick_idx;
                    state            <= ISSUE;
                end
                ISSUE: if (alloc_req_rdy_i) begin
                    alloc_req_val_o <= 1'b0;
                    alloc_rsp_rdy_o <= 1'b1;
                    state           <= WAIT;
                end
                WAIT: if (alloc_rsp_val_i) begin
                    alloc_rsp_rdy_o <= 1'b0;
                    cli_rsp_addr_o  <= alloc_rsp_addr_i;
                    cli_rsp_ok_o    <= alloc_rsp_ok_i;
                    cli_rsp_val_o   <= N_CLIENTS'(1) << grant;
                    state           <= RESP;
                end
                RESP: if (cli_rsp_rdy_i[grant]) begin
                    cli_rsp_val_o <= '0;
                    rr_ptr        <= next_rr;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
            // A downstream response nobody asked for is dropped but remembered.
            if (alloc_rsp_val_i && state != WAIT)
                proto_err_o <= 1'b1;
        end
    end
endmodule

// File: doc/falafel_mux.md
FALAFEL_MUX -- requirements
Module: falafel_mux

Interface
REQ-001 SHALL have parameter DATA_W, default 64, address/size/data width.
REQ-002 SHALL have parameter N_CLIENTS, default 4, legal range 1..16, number of client ports.
REQ-003 SHALL define localparam ID_W = max(1, clog2(N_CLIENTS)).
REQ-004 clk_i  in  1  single clock; all state on rising edge.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 cli_req_val_i  in  N_CLIENTS  per-client request valid.
REQ-007 cli_req_rdy_o  out  N_CLIENTS  per-client request ready; equals "buffer i empty".
REQ-008 cli_is_alloc_i  in  N_CLIENTS  1 = alloc, 0 = free.
REQ-009 cli_size_i  in  N_CLIENTS*DATA_W  alloc size, client i at slice i.
REQ-010 cli_addr_i  in  N_CLIENTS*DATA_W  address to free, client i at slice i.
REQ-011 cli_rsp_val_o  out  N_CLIENTS  per-client response valid, one-hot or zero.
REQ-012 cli_rsp_rdy_i  in  N_CLIENTS  per-client response ready.
REQ-013 cli_rsp_addr_o  out  DATA_W  shared response address.
REQ-014 cli_rsp_ok_o  out  1  shared response success flag.
REQ-015 alloc_req_val_o / alloc_req_rdy_i  out/in  1  downstream allocator request handshake.
REQ-016 alloc_is_alloc_o, alloc_size_o, alloc_addr_o, alloc_id_o  out  1/DATA_W/DATA_W/ID_W  downstream request payload.
REQ-017 alloc_rsp_val_i / alloc_rsp_rdy_o  in/out  1  downstream response handshake.
REQ-018 alloc_rsp_addr_i, alloc_rsp_ok_i  in  DATA_W/1  downstream response payload.
REQ-019 proto_err_o  out  1  sticky protocol error flag.

Function
REQ-020 Per client: one-entry request buffer {is_alloc, size, addr}; loaded on cli_req_val_i & cli_req_rdy_o; cleared only at that client's response handshake (at most one outstanding request per client).
REQ-021 FSM states IDLE, ISSUE, WAIT, RESP.
REQ-022 IDLE: if any buffer full, grant = first full index scanning rr_ptr, rr_ptr+1, ... modulo N_CLIENTS; latch grant, go ISSUE; else stay.
REQ-023 ISSUE: alloc_req_val_o = 1 with payload from buffer[grant] and alloc_id_o = grant, held stable until alloc_req_rdy_i; on handshake go WAIT.
REQ-024 WAIT: alloc_rsp_rdy_o = 1; on alloc_rsp_val_i register addr and ok, go RESP.
REQ-025 RESP: cli_rsp_val_o[grant] = 1, all other bits 0, addr/ok held; on cli_rsp_rdy_i[grant] clear buffer[grant], rr_ptr = (grant+1) mod N_CLIENTS, go IDLE.
REQ-026 alloc_rsp_rdy_o SHALL be 0 outside WAIT; alloc_rsp_val_i outside WAIT is ignored and sets proto_err_o.
REQ-027 Latency: client handshake at cycle 0 with all idle -> alloc_req_val_o high at cycle 2; downstream response accepted at cycle k -> cli_rsp_val_o high at cycle k+1.
REQ-028 A new request from a client whose buffer is freed is accepted no earlier than the cycle after its response handshake.
REQ-029 Payload passes unmodified; size 0 and free of address 0 forwarded as-is.
REQ-030 N_CLIENTS = 1: rr_ptr constant 0, arbitration degenerates to single client.
REQ-031 rr_ptr wraps from N_CLIENTS-1 to 0.
REQ-032 proto_err_o remains 1 until reset.

Reset
REQ-033 On rst_ni low (asynchronous): FSM IDLE, all buffers empty, rr_ptr 0, grant 0, proto_err_o 0, alloc_req_val_o 0, alloc_rsp_rdy_o 0, cli_rsp_val_o 0, cli_rsp_addr_o 0, cli_rsp_ok_o 0, alloc payload outputs 0.
REQ-034 cli_req_rdy_o reads all-ones after reset; client handshakes while rst_ni low are discarded.
REQ-035 Reset mid-transaction drops the in-flight request and any buffered requests; no response is generated.

Verification
REQ-036 Single alloc: client 2 size 0x40, downstream rdy=1, responds addr 0x1000 ok=1 two cycles later -> alloc_req_val_o at cycle 2 with id 2, cli_rsp_val_o = 4'b0100, addr 0x1000, ok 1.
REQ-037 Fairness: all 4 clients request simultaneously, repeatedly -> grant order 0,1,2,3,0,... with no client served twice before others.
REQ-038 Backpressure: alloc_req_rdy_i low 5 cycles, cli_rsp_rdy_i low 3 cycles -> payload and response stable throughout; one response only.
REQ-039 Free failure: client 1 free addr 0x2000, downstream ok=0 -> cli_rsp_ok_o 0, buffer 1 cleared, cli_req_rdy_o[1] high next cycle.
REQ-040 Stray response in IDLE -> ignored, alloc_rsp_rdy_o 0, proto_err_o 1 next cycle and sticky.
REQ-041 Reset asserted in WAIT -> all outputs reset values immediately, no cli_rsp_val_o after release.
